// File: rtl/mdr_read_ctrl_pkg.sv
// mdr_pkg: shared types and defaults for the MDR read controller.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Contents: FSM state enum, default widths, timeout counter width helper.
package mdr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MDR_DATA_W  = 32;
  localparam int MDR_ADDR_W  = 9;
  localparam int MDR_TIMEOUT = 15;

  // Counter must be able to represent 0..TIMEOUT.
  function automatic int to_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int MDR_TO_CNT_W = to_cnt_w(MDR_TIMEOUT);

endpackage

// File: rtl/mdr_read_ctrl_if.sv
// mdr_read_ctrl_if: control-unit, CPU-bus and memory signals of the MDR read path.
// Latency: n/a (wiring only). Backpressure: memory paces reads through mem_ready.
// Modports: slave = controller side, master = control unit / memory / bench side.
interface mdr_read_ctrl_if
  import mdr_pkg::*;
#(
  parameter int DATA_W = MDR_DATA_W,
  parameter int ADDR_W = MDR_ADDR_W
);

  logic              rd_start;
  logic [ADDR_W-1:0] mar_addr;
  logic              mdr_in;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mdr_q;
  logic              busy;
  logic              rd_done;
  logic              rd_err;

  modport slave (
    input  rd_start, mar_addr, mdr_in, bus_in, mem_rdata, mem_ready,
    output mem_addr, mem_rd_en, mdr_q, busy, rd_done, rd_err
  );

  modport master (
    output rd_start, mar_addr, mdr_in, bus_in, mem_rdata, mem_ready,
    input  mem_addr, mem_rd_en, mdr_q, busy, rd_done, rd_err
  );

endinterface

// File: rtl/mdr_read_ctrl_timeout_cnt.sv
// mdr_timeout_cnt: counts WAIT cycles and flags the last allowed one.
// Latency: expired is a combinational decode of the count during the final WAIT cycle.
// Backpressure: none; start clears, run advances. Ports: clk, clr, start, run -> expired.
module mdr_timeout_cnt
  import mdr_pkg::*;
#(
  parameter int TIMEOUT = MDR_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = to_cnt_w(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt counts completed WAIT cycles, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_read_ctrl.sv
// mdr_read_ctrl: Mini SRC memory-read controller with its own MDR (bus loads when idle).
// Latency: rd_start to rd_done >= 3 cycles; bus load visible next cycle; all outputs registered.
// Backpressure: waits on mem_ready; requests while busy are dropped. Optional macro MEM_TIMEOUT_EN.
// Ports: clk, clr (sync active-high), bus (mdr_read_ctrl_if.slave).
module mdr_read_ctrl
  import mdr_pkg::*;
#(
  parameter int DATA_W = MDR_DATA_W,
  parameter int ADDR_W = MDR_ADDR_W
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = MDR_TIMEOUT
`endif
) (
  input  logic clk,
  input  logic clr,
  mdr_read_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mdr_r, mdr_d;
  logic              rd_en_r;
  logic              done_r;
  logic              busy_r;

`ifdef MEM_TIMEOUT_EN
  logic timeout_hit;
  logic err_d;
  logic err_r;

  // Counter is cleared during REQ so it reads 0 on the first WAIT cycle.
  mdr_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .clr     (clr),
    .start   (state_q == REQ),
    .run     (state_q == WAIT),
    .expired (timeout_hit)
  );
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mdr_d   = mdr_r;
`ifdef MEM_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A read request takes priority over a bus load in the same cycle.
        if (bus.rd_start) begin
          addr_d  = bus.mar_addr;
          state_d = REQ;
        end else if (bus.mdr_in) begin
          mdr_d = bus.bus_in;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A response arriving on the expiry cycle still counts as success.
        if (bus.mem_ready) begin
          mdr_d   = bus.mem_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mdr_r   <= '0;
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mdr_r   <= mdr_d;
      rd_en_r <= (state_d == REQ);
      done_r  <= (state_d == DONE);
      busy_r  <= (state_d != IDLE);
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_d;
    end
  end
  assign bus.rd_err = err_r;
`else
  assign bus.rd_err = 1'b0;
`endif

  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_en_r;
  assign bus.mdr_q     = mdr_r;
  assign bus.busy      = busy_r;
  assign bus.rd_done   = done_r;

endmodule

// File: tb/tb_mdr_read_ctrl.sv
// tb_mdr_read_ctrl: directed vector table plus hand-written multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge. Backpressure: memory modelled by direct mem_ready drive.
// Covers reset, zero-wait and slow reads, bus-load priority, ignored requests, reset mid-read, timeout (MEM_TIMEOUT_EN).
module tb_mdr_read_ctrl;

  logic clk;
  logic clr;

  mdr_read_ctrl_if #(.DATA_W(32), .ADDR_W(9)) ifc ();

  mdr_read_ctrl dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd_start;
    logic [8:0]  mar_addr;
    logic        mdr_in;
    logic [31:0] bus_in;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_rd_en;
    logic        e_done;
    logic        e_busy;
    logic [31:0] e_mdr;
    logic [8:0]  e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rs, input logic [8:0] ma, input logic mi,
                              input logic [31:0] bi, input logic mr, input logic [31:0] rdat,
                              input logic en, input logic dn, input logic bz,
                              input logic [31:0] mq, input logic [8:0] ad);
    vec_t v;
    v.rd_start = rs; v.mar_addr = ma; v.mdr_in = mi; v.bus_in = bi;
    v.mem_ready = mr; v.mem_rdata = rdat;
    v.e_rd_en = en; v.e_done = dn; v.e_busy = bz; v.e_mdr = mq; v.e_addr = ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.rd_start  = 1'b0;
    ifc.mar_addr  = '0;
    ifc.mdr_in    = 1'b0;
    ifc.bus_in    = '0;
    ifc.mem_ready = 1'b0;
    ifc.mem_rdata = '0;
  endtask

  task automatic chk_all(input string tag, input logic en, input logic dn, input logic er,
                         input logic bz, input logic [31:0] mq, input logic [8:0] ad);
    chk({tag, " mem_rd_en"}, 32'(ifc.mem_rd_en), 32'(en));
    chk({tag, " rd_done"},   32'(ifc.rd_done),   32'(dn));
    chk({tag, " rd_err"},    32'(ifc.rd_err),    32'(er));
    chk({tag, " busy"},      32'(ifc.busy),      32'(bz));
    chk({tag, " mdr_q"},     ifc.mdr_q,          mq);
    chk({tag, " mem_addr"},  32'(ifc.mem_addr),  32'(ad));
  endtask

  initial begin
    idle_inputs();
    clr = 1'b1;

    // Reset state.
    step();
    step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 9'h0);
    clr = 1'b0;

    //          rs   addr    mi   bus_in        mr   rdata         en dn bz  mdr           addr
    vecs.push_back(mk(0, 9'h000, 1, 32'h12345678, 0, 32'h0,        0, 0, 0, 32'h12345678, 9'h000)); // bus load
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h12345678, 9'h000));
    vecs.push_back(mk(1, 9'h0A5, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h12345678, 9'h0A5)); // REQ
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h12345678, 9'h0A5)); // WAIT
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 9'h0A5)); // DONE
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 9'h0A5)); // IDLE
    vecs.push_back(mk(1, 9'h1FF, 1, 32'hCAFEF00D, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF, 9'h1FF)); // read beats bus load
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'h11111111, 0, 0, 1, 32'hDEADBEEF, 9'h1FF)); // ready in REQ ignored
    vecs.push_back(mk(1, 9'h055, 1, 32'h22222222, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 9'h1FF)); // requests in WAIT ignored
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 9'h1FF));
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'h0BADF00D, 0, 1, 1, 32'h0BADF00D, 9'h1FF));
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'h33333333, 0, 0, 0, 32'h0BADF00D, 9'h1FF)); // ready in DONE ignored
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'h44444444, 0, 0, 0, 32'h0BADF00D, 9'h1FF)); // ready in IDLE ignored
    vecs.push_back(mk(1, 9'h003, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h0BADF00D, 9'h003));
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0BADF00D, 9'h003));
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'h5A5A5A5A, 0, 1, 1, 32'h5A5A5A5A, 9'h003));
    vecs.push_back(mk(1, 9'h004, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h5A5A5A5A, 9'h003)); // rd_start in DONE ignored
    vecs.push_back(mk(1, 9'h004, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h5A5A5A5A, 9'h004)); // back-to-back accepted
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h5A5A5A5A, 9'h004));
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 32'hA5A5A5A5, 0, 1, 1, 32'hA5A5A5A5, 9'h004));
    vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'hA5A5A5A5, 9'h004));

    foreach (vecs[i]) begin
      ifc.rd_start  = vecs[i].rd_start;
      ifc.mar_addr  = vecs[i].mar_addr;
      ifc.mdr_in    = vecs[i].mdr_in;
      ifc.bus_in    = vecs[i].bus_in;
      ifc.mem_ready = vecs[i].mem_ready;
      ifc.mem_rdata = vecs[i].mem_rdata;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rd_en, vecs[i].e_done, 1'b0,
              vecs[i].e_busy, vecs[i].e_mdr, vecs[i].e_addr);
    end
    idle_inputs();

    // Slow memory: rd_start in cycle 0, mem_ready in cycle 6 (5 cycles into WAIT).
    for (int c = 0; c <= 8; c++) begin
      ifc.rd_start  = (c == 0);
      ifc.mar_addr  = 9'h100;
      ifc.mem_ready = (c == 6);
      ifc.mem_rdata = 32'h600DCAFE;
      chk_all($sformatf("slow c%0d", c), (c == 1), (c == 7), 1'b0, (c >= 1 && c <= 7),
              (c >= 7) ? 32'h600DCAFE : 32'hA5A5A5A5, (c >= 1) ? 9'h100 : 9'h004);
      step();
    end
    idle_inputs();

    // Reset held for 2 cycles during WAIT, then a late mem_ready.
    ifc.rd_start = 1'b1;
    ifc.mar_addr = 9'h0F0;
    step();
    idle_inputs();
    step();
    step();
    chk("pre-clr busy", 32'(ifc.busy), 32'h1);
    clr = 1'b1;
    step();
    chk_all("clr1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 9'h0);
    step();
    chk_all("clr2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 9'h0);
    clr = 1'b0;
    ifc.mem_ready = 1'b1;
    ifc.mem_rdata = 32'hFFFFFFFF;
    step();
    chk_all("late ready", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 9'h0);
    idle_inputs();
    step();
    chk_all("post clr", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 9'h0);

`ifdef MEM_TIMEOUT_EN
    // Timeout: no mem_ready, rd_done and rd_err pulse together in cycle 17.
    ifc.mdr_in = 1'b1;
    ifc.bus_in = 32'h77777777;
    step();
    idle_inputs();
    for (int c = 0; c <= 18; c++) begin
      ifc.rd_start = (c == 0);
      ifc.mar_addr = 9'h0AA;
      chk_all($sformatf("tmo c%0d", c), (c == 1), (c == 17), (c == 17), (c >= 1 && c <= 17),
              32'h77777777, (c >= 1) ? 9'h0AA : 9'h000);
      step();
    end
    idle_inputs();
    ifc.rd_start = 1'b1;
    ifc.mar_addr = 9'h0BB;
    step();
    idle_inputs();
    step();
    ifc.mem_ready = 1'b1;
    ifc.mem_rdata = 32'h88888888;
    step();
    chk_all("after tmo", 1'b0, 1'b1, 1'b0, 1'b1, 32'h88888888, 9'h0BB);
    idle_inputs();
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
